shiftreg_rx: RTL and testbench
==============================

Name: shiftreg_rx

Overview:
Serial-in, parallel-out receiver, the counterpart of the team's parallel-load, MSB-first shift-register transmitter. Accepts one bit per qualified clock, MSB first, and assembles WIDTH-bit words. Presents each completed word on a valid/ready output interface, with a sticky overrun flag. Sits at the far end of the single-wire serial link, feeding downstream parallel logic.

Parameters:
WIDTH, 8, word length in bits; legal range is 2 or more.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
i_bit  input  1  serial data bit, MSB of each word first
i_bit_vld  input  1  i_bit is sampled on this edge when high
i_sync  input  1  word-alignment marker; qualified by i_bit_vld, see Behaviour
o_data  output  WIDTH  last completed word
o_data_vld  output  1  o_data holds an unconsumed word
i_data_rdy  input  1  downstream accepts o_data this cycle
o_overrun  output  1  sticky: a completed word was dropped
i_clr_ovr  input  1  clears o_overrun
o_bit_cnt  output  $clog2(WIDTH)  bits collected toward the current word (debug/status)

Behaviour:
- Reset (rst_n low at a clk edge; synchronous only): shift register = 0, bit counter = 0, o_data = 0, o_data_vld = 0, o_overrun = 0. Reset wins over every other input. A partial word is discarded on reset.
- Shift:
  - On an edge with i_bit_vld = 1: shreg <= {shreg[WIDTH-2:0], i_bit}, and the counter increments.
  - With i_bit_vld = 0: shreg and the counter hold.
- Sync:
  - i_sync = 1 with i_bit_vld = 1: the partial word is discarded, this bit becomes the MSB of a new word, and the counter becomes 1.
  - i_sync = 1 with i_bit_vld = 0: the counter becomes 0 and shreg is left unchanged (don't-care).
- Completion: when a bit is accepted while counter == WIDTH-1, the word {shreg[WIDTH-2:0], i_bit} is complete and the counter wraps to 0. For WIDTH 2 or more, i_sync on that same bit restarts the framing instead, and no word completes.
- Output register, evaluated at each edge with a completing bit:
  - Slot free, meaning o_data_vld = 0, or o_data_vld = 1 and i_data_rdy = 1 in that same cycle: o_data <= word and o_data_vld <= 1 on the next edge. The simultaneous accept-and-complete case gives no bubble and no overrun.
  - Slot occupied and not accepted: the new word is dropped, o_data is unchanged, and o_overrun <= 1.
- Handshake:
  - Transfer occurs when o_data_vld & i_data_rdy at an edge.
  - Without a new completion, o_data_vld <= 0 after a transfer.
  - o_data is stable while o_data_vld = 1 and not accepted.
  - i_data_rdy is ignored while o_data_vld = 0.
- Latency: the last bit of a word is sampled at edge N; o_data/o_data_vld are visible after edge N, i.e. in cycle N+1. Back-to-back streaming (i_bit_vld held high) yields one word every WIDTH cycles.
- Overrun:
  - o_overrun is set by a drop and cleared by i_clr_ovr.
  - If a drop and i_clr_ovr occur in the same cycle, set wins.
  - Overrun does not disturb framing.
- o_bit_cnt equals the internal counter (0..WIDTH-1).
- Link pairing: connecting the transmitter output to i_bit, with i_bit_vld = 1 and i_sync asserted on the cycle of the transmitter's first shifted-out bit (the cycle after its load), reproduces the transmitted byte.

Decomposition:
- The shared package holds:
  - the default word-width constant (8);
  - a counter-width function (clog2 of WIDTH, minimum 1).
- A single module; no sub-module is warranted. The shift/count datapath and the one-entry output slot are both small.

Test Plan:
1. Reset, then stream 0xA5 MSB-first (1,0,1,0,0,1,0,1) with i_bit_vld = 1, i_sync on the first bit, i_data_rdy = 1 -> o_data = 8'hA5 and o_data_vld = 1 exactly one cycle after the 8th bit; o_data_vld = 0 on the following cycle.
2. Gapped input: 0x3C with i_bit_vld low for 2 cycles between every bit -> o_data = 8'h3C, o_data_vld asserted once, o_bit_cnt steps 1..7 then 0.
3. Realignment: 3 bits of garbage, then i_sync with 0xF0 -> o_data = 8'hF0, and no word is produced from the garbage.
4. Backpressure: i_data_rdy = 0 while 0x11 and then 0x22 complete -> o_data stays 8'h11, o_data_vld = 1, o_overrun = 1. Then i_data_rdy = 1 for one cycle -> o_data_vld = 0. Then i_clr_ovr -> o_overrun = 0.
5. Simultaneous accept-and-complete: hold 0x55 unaccepted; raise i_data_rdy in the exact cycle 0xAA's last bit is sampled -> o_data becomes 8'hAA next cycle, o_data_vld stays 1, o_overrun stays 0.
6. Reset mid-word: pull rst_n low for one edge after 4 bits of 0xFF -> all outputs 0 and the counter is 0; a following full 0x81 is received correctly. Asynchronous rst_n pulses that never span a clk edge have no effect.

Source files
------------

// File: rtl/shiftreg_rx_pkg.sv
// Shared constants and helpers for the serial-in, parallel-out receiver.
// Imported by the interface, the receiver and its bench.
package shiftreg_rx_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width: clog2 of the word length, never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/shiftreg_rx_if.sv
// Parallel word output of the receiver: one-entry valid/ready slot.
// The receiver drives the master side; downstream logic uses the slave side.
interface shiftreg_rx_if
    import shiftreg_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] o_data;
    logic             o_data_vld;
    logic             i_data_rdy;

    modport master (
        output o_data,
        output o_data_vld,
        input  i_data_rdy
    );

    modport slave (
        input  o_data,
        input  o_data_vld,
        output i_data_rdy
    );

endinterface

// File: rtl/shiftreg_rx.sv
// Serial-in, parallel-out receiver: assembles MSB-first words and presents them
// on a valid/ready slot with a sticky overrun flag for dropped words.
module shiftreg_rx
    import shiftreg_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_bit,
    input  logic                       i_bit_vld,
    input  logic                       i_sync,
    input  logic                       i_clr_ovr,
    output logic                       o_overrun,
    output logic [cnt_width(WIDTH)-1:0] o_bit_cnt,
    shiftreg_rx_if.master              out_if
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             data_vld_q, data_vld_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             slot_free;

    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        word      = {shreg_q[WIDTH-2:0], i_bit};
        if (i_bit_vld) begin
            if (i_sync) begin
                // Sync bit starts a fresh word; older contents are discarded.
                shreg_d = {{(WIDTH-1){1'b0}}, i_bit};
                cnt_d   = CNT_W'(1);
            end else begin
                shreg_d = word;
                if (cnt_q == LAST_CNT) begin
                    cnt_d     = '0;
                    word_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else if (i_sync) begin
            cnt_d = '0;
        end
    end

    // A completed word may replace one being accepted in the same cycle.
    always_comb begin
        slot_free  = !data_vld_q || out_if.i_data_rdy;
        data_d     = data_q;
        data_vld_d = data_vld_q && !out_if.i_data_rdy;
        ovr_d      = ovr_q && !i_clr_ovr;
        if (word_done) begin
            if (slot_free) begin
                data_d     = word;
                data_vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q    <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            data_vld_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            data_vld_q <= data_vld_d;
            ovr_q      <= ovr_d;
        end
    end

    assign out_if.o_data     = data_q;
    assign out_if.o_data_vld = data_vld_q;
    assign o_overrun         = ovr_q;
    assign o_bit_cnt         = cnt_q;

endmodule

// File: tb/tb_shiftreg_rx.sv
// Self-checking bench for shiftreg_rx: directed scenarios then random traffic,
// all compared against a queue-based word-assembly model.
module tb_shiftreg_rx;
    import shiftreg_rx_pkg::*;

    localparam int W  = DEFAULT_WIDTH;
    localparam int CW = cnt_width(W);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_bit = 1'b0;
    logic          i_bit_vld = 1'b0;
    logic          i_sync = 1'b0;
    logic          i_clr_ovr = 1'b0;
    logic          o_overrun;
    logic [CW-1:0] o_bit_cnt;

    shiftreg_rx_if #(.WIDTH(W)) rx_if ();

    shiftreg_rx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_bit     (i_bit),
        .i_bit_vld (i_bit_vld),
        .i_sync    (i_sync),
        .i_clr_ovr (i_clr_ovr),
        .o_overrun (o_overrun),
        .o_bit_cnt (o_bit_cnt),
        .out_if    (rx_if)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: bits gathered so far for the current word, plus the output slot.
    bit         m_q[$];
    logic [W-1:0] m_data = '0;
    bit         m_vld = 1'b0;
    bit         m_ovr = 1'b0;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".data"}, 32'(rx_if.o_data), 32'(m_data));
        checkValue({tag, ".vld"}, 32'(rx_if.o_data_vld), 32'(m_vld));
        checkValue({tag, ".ovr"}, 32'(o_overrun), 32'(m_ovr));
        checkValue({tag, ".cnt"}, 32'(o_bit_cnt), 32'(m_q.size()));
    endtask

    function automatic void modelEdge(input bit rst_b, input bit b, input bit vld,
                                      input bit sync, input bit rdy, input bit clr);
        bit           done;
        bit           was_vld;
        logic [W-1:0] word;
        done = 1'b0;
        word = '0;
        if (!rst_b) begin
            m_q.delete();
            m_data = '0;
            m_vld  = 1'b0;
            m_ovr  = 1'b0;
            return;
        end
        if (vld) begin
            if (sync) m_q.delete();
            m_q.push_back(b);
            if (!sync && m_q.size() == W) begin
                foreach (m_q[i]) word = (word << 1) | W'(m_q[i]);
                m_q.delete();
                done = 1'b1;
            end
        end else if (sync) begin
            m_q.delete();
        end
        was_vld = m_vld;
        if (m_vld && rdy) m_vld = 1'b0;
        if (clr) m_ovr = 1'b0;
        if (done) begin
            if (!was_vld || rdy) begin
                m_data = word;
                m_vld  = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end
    endfunction

    task automatic applyStimulus(input bit b, input bit vld, input bit sync,
                                 input bit rdy, input bit clr, input string tag);
        @(negedge clk);
        rst_n            = 1'b1;
        i_bit            = b;
        i_bit_vld        = vld;
        i_sync           = sync;
        rx_if.i_data_rdy = rdy;
        i_clr_ovr        = clr;
        modelEdge(1'b1, b, vld, sync, rdy, clr);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Reset edge with busy inputs to show reset dominates.
    task automatic doReset(input string tag);
        @(negedge clk);
        rst_n            = 1'b0;
        i_bit            = 1'b1;
        i_bit_vld        = 1'b1;
        i_sync           = 1'b0;
        rx_if.i_data_rdy = 1'b0;
        i_clr_ovr        = 1'b0;
        modelEdge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic sendWord(input logic [W-1:0] val, input bit sync_first, input int gap,
                            input bit rdy, input bit rdy_last, input string tag);
        for (int i = W - 1; i >= 0; i--) begin
            applyStimulus(val[i], 1'b1, sync_first && (i == W - 1),
                          (i == 0) ? rdy_last : rdy, 1'b0, tag);
            if (i != 0)
                for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 1'b0, rdy, 1'b0, tag);
        end
    endtask

    initial begin
        logic [W-1:0] v;

        doReset("reset");
        checkValue("reset.vld_const", 32'(rx_if.o_data_vld), 32'd0);

        // Test 1: back-to-back 0xA5
        sendWord(8'hA5, 1'b1, 0, 1'b1, 1'b1, "t1");
        checkValue("t1.data_const", 32'(rx_if.o_data), 32'hA5);
        checkValue("t1.vld_const", 32'(rx_if.o_data_vld), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t1.drain");
        checkValue("t1.vld_after", 32'(rx_if.o_data_vld), 32'd0);

        // Test 2: gapped 0x3C, counter steps 1..7 then 0
        v = 8'h3C;
        for (int i = W - 1; i >= 0; i--) begin
            applyStimulus(v[i], 1'b1, 1'b0, 1'b1, 1'b0, "t2");
            checkValue("t2.cnt_const", 32'(o_bit_cnt), 32'((W - i) % W));
            if (i != 0) begin
                checkValue("t2.vld_low", 32'(rx_if.o_data_vld), 32'd0);
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t2.gap");
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t2.gap");
            end
        end
        checkValue("t2.data_const", 32'(rx_if.o_data), 32'h3C);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t2.drain");

        // Test 3: garbage then realign on 0xF0
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "t3.garbage");
        sendWord(8'hF0, 1'b1, 0, 1'b1, 1'b1, "t3");
        checkValue("t3.data_const", 32'(rx_if.o_data), 32'hF0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t3.drain");

        // Test 4: backpressure and overrun
        sendWord(8'h11, 1'b1, 0, 1'b0, 1'b0, "t4.w1");
        sendWord(8'h22, 1'b1, 0, 1'b0, 1'b0, "t4.w2");
        checkValue("t4.data_const", 32'(rx_if.o_data), 32'h11);
        checkValue("t4.ovr_const", 32'(o_overrun), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t4.accept");
        checkValue("t4.vld_const", 32'(rx_if.o_data_vld), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t4.clr");
        checkValue("t4.ovr_clr", 32'(o_overrun), 32'd0);

        // Test 5: accept and complete on the same edge
        sendWord(8'h55, 1'b1, 0, 1'b0, 1'b0, "t5.w1");
        sendWord(8'hAA, 1'b1, 0, 1'b0, 1'b1, "t5.w2");
        checkValue("t5.data_const", 32'(rx_if.o_data), 32'hAA);
        checkValue("t5.vld_const", 32'(rx_if.o_data_vld), 32'd1);
        checkValue("t5.ovr_const", 32'(o_overrun), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t5.drain");

        // Test 6: reset mid-word, then a glitch that never spans an edge
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, i == 0, 1'b1, 1'b0, "t6.partial");
        doReset("t6.reset");
        checkValue("t6.cnt_const", 32'(o_bit_cnt), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t6.bit");
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        checkOutput("t6.glitch");
        v = 8'h81;
        for (int i = W - 2; i >= 0; i--) applyStimulus(v[i], 1'b1, 1'b0, 1'b0, 1'b0, "t6.w");
        checkValue("t6.data_const", 32'(rx_if.o_data), 32'h81);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(99) == 0) begin
                doReset("rand.reset");
            end else begin
                applyStimulus(1'($urandom), $urandom_range(99) < 70, $urandom_range(99) < 5,
                              $urandom_range(99) < 50, $urandom_range(99) < 10, "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
